// File: rtl/mc_wdb.sv
// Write-data buffer: stores BL-beat write bursts per pointer-addressed entry with
// byte masks and byte parity, and streams a selected entry onto the DFI write-data bus.
module mc_wdb #(
  parameter int DW    = 64,
  parameter int DEPTH = 8,
  parameter int BL    = 2,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              wr,
  input  logic [AW-1:0]     wr_ptr,
  input  logic [DW-1:0]     wr_data,
  input  logic [DW/8-1:0]   wr_mask,
  input  logic              wr_par_inj,
  input  logic              rd,
  input  logic [AW-1:0]     rd_ptr,
  input  logic              rd_free,
  input  logic              err_clr,
  output logic              dfi_wrdata_en,
  output logic [DW-1:0]     dfi_wrdata,
  output logic [DW/8-1:0]   dfi_wrdata_mask,
  output logic              rd_busy,
  output logic [DEPTH-1:0]  valid_vec,
  output logic              fir,
  output logic [3:0]        err_code
);

  localparam int NB = DW / 8;
  localparam int CW = (BL > 1) ? $clog2(BL) : 1;

  typedef enum logic {IDLE, STREAM} state_t;

  function automatic logic [NB-1:0] byte_par(input logic [DW-1:0] d);
    logic [NB-1:0] p;
    for (int b = 0; b < NB; b++) p[b] = ^d[8*b +: 8];
    return p;
  endfunction

  // Beat storage; contents are never reset, validity lives in valid_vec.
  logic [DW-1:0] data_mem [DEPTH][BL];
  logic [NB-1:0] mask_mem [DEPTH][BL];
  logic [NB-1:0] par_mem  [DEPTH][BL];

  state_t           state, state_next;
  logic [CW-1:0]    wcnt, wcnt_next, rcnt, rcnt_next;
  logic [AW-1:0]    wp, wp_next, rp, rp_next;
  logic             fr, fr_next;
  logic [DEPTH-1:0] valid_next;
  logic [3:0]       err_next, new_err;
  logic [NB-1:0]    out_par;

  logic             mem_we;
  logic [AW-1:0]    mem_ptr;
  logic [CW-1:0]    mem_beat;
  logic [NB-1:0]    wr_par;
  logic             set_valid;
  logic [AW-1:0]    set_ptr;
  logic             issue, last, accept;
  logic [DW-1:0]    beat_data;
  logic [NB-1:0]    beat_mask, beat_par;

  assign wr_par    = byte_par(wr_data) ^ NB'(wr_par_inj);
  assign issue     = (state == STREAM);
  assign last      = issue && (rcnt == CW'(BL - 1));
  // A new stream may start on the final issue cycle so consecutive streams abut.
  assign accept    = rd && valid_vec[rd_ptr] && (state == IDLE || last);
  assign beat_data = data_mem[rp][rcnt];
  assign beat_mask = mask_mem[rp][rcnt];
  assign beat_par  = par_mem[rp][rcnt];
  assign fir       = |err_code;

  always_comb begin
    mem_we     = 1'b0;
    mem_ptr    = wr_ptr;
    mem_beat   = '0;
    wcnt_next  = wcnt;
    wp_next    = wp;
    set_valid  = 1'b0;
    set_ptr    = wr_ptr;
    new_err    = '0;
    state_next = state;
    rp_next    = rp;
    fr_next    = fr;
    rcnt_next  = rcnt;

    if (wr) begin
      if (wcnt == '0) begin
        wp_next = wr_ptr;
        if (valid_vec[wr_ptr]) begin
          new_err[0] = 1'b1;
        end else begin
          mem_we = 1'b1;
          if (BL == 1) set_valid = 1'b1;
          else         wcnt_next = CW'(1);
        end
      end else if (wr_ptr == wp) begin
        mem_we   = 1'b1;
        mem_ptr  = wp;
        mem_beat = wcnt;
        if (wcnt == CW'(BL - 1)) begin
          set_valid = 1'b1;
          set_ptr   = wp;
          wcnt_next = '0;
        end else begin
          wcnt_next = wcnt + CW'(1);
        end
      end else begin
        new_err[3] = 1'b1;
        wcnt_next  = '0;
      end
    end

    if (rd && !accept) new_err[1] = 1'b1;
    if (accept) begin
      state_next = STREAM;
      rp_next    = rd_ptr;
      fr_next    = rd_free;
      rcnt_next  = '0;
    end else if (last) begin
      state_next = IDLE;
    end else if (issue) begin
      rcnt_next = rcnt + CW'(1);
    end

    // Parity is checked on the beat currently on the bus.
    if (dfi_wrdata_en && (byte_par(dfi_wrdata) != out_par)) new_err[2] = 1'b1;

    // Freeing is applied first, so a same-edge write never sees the entry freed.
    valid_next = valid_vec;
    if (last && fr) valid_next[rp] = 1'b0;
    if (set_valid)  valid_next[set_ptr] = 1'b1;

    err_next = (err_clr ? 4'b0000 : err_code) | new_err;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state           <= IDLE;
      wcnt            <= '0;
      wp              <= '0;
      rp              <= '0;
      fr              <= 1'b0;
      rcnt            <= '0;
      valid_vec       <= '0;
      err_code        <= '0;
      dfi_wrdata_en   <= 1'b0;
      dfi_wrdata      <= '0;
      dfi_wrdata_mask <= '0;
      out_par         <= '0;
      rd_busy         <= 1'b0;
    end else begin
      state           <= state_next;
      wcnt            <= wcnt_next;
      wp              <= wp_next;
      rp              <= rp_next;
      fr              <= fr_next;
      rcnt            <= rcnt_next;
      valid_vec       <= valid_next;
      err_code        <= err_next;
      dfi_wrdata_en   <= issue;
      dfi_wrdata      <= issue ? beat_data : '0;
      dfi_wrdata_mask <= issue ? beat_mask : '0;
      out_par         <= issue ? beat_par : '0;
      rd_busy         <= issue;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      data_mem[mem_ptr][mem_beat] <= wr_data;
      mask_mem[mem_ptr][mem_beat] <= wr_mask;
      par_mem[mem_ptr][mem_beat]  <= wr_par;
    end
  end

endmodule

// File: tb/tb_mc_wdb.sv
// Directed bench for mc_wdb with DW=64, DEPTH=8, BL=2; expected values are hand-derived.
module tb_mc_wdb;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        wr = 1'b0;
  logic [2:0]  wr_ptr = '0;
  logic [63:0] wr_data = '0;
  logic [7:0]  wr_mask = '0;
  logic        wr_par_inj = 1'b0;
  logic        rd = 1'b0;
  logic [2:0]  rd_ptr = '0;
  logic        rd_free = 1'b0;
  logic        err_clr = 1'b0;
  logic        dfi_wrdata_en;
  logic [63:0] dfi_wrdata;
  logic [7:0]  dfi_wrdata_mask;
  logic        rd_busy;
  logic [7:0]  valid_vec;
  logic        fir;
  logic [3:0]  err_code;

  int n_tests = 0;
  int n_fail  = 0;

  mc_wdb #(.DW(64), .DEPTH(8), .BL(2)) dut (
    .clk(clk), .rstn(rstn),
    .wr(wr), .wr_ptr(wr_ptr), .wr_data(wr_data), .wr_mask(wr_mask), .wr_par_inj(wr_par_inj),
    .rd(rd), .rd_ptr(rd_ptr), .rd_free(rd_free), .err_clr(err_clr),
    .dfi_wrdata_en(dfi_wrdata_en), .dfi_wrdata(dfi_wrdata), .dfi_wrdata_mask(dfi_wrdata_mask),
    .rd_busy(rd_busy), .valid_vec(valid_vec), .fir(fir), .err_code(err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end else begin
      $display("ok   %s: %h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wbeat(input logic [2:0] p, input logic [63:0] d, input logic [7:0] m, input logic inj);
    wr = 1'b1; wr_ptr = p; wr_data = d; wr_mask = m; wr_par_inj = inj;
    tick();
    wr = 1'b0; wr_par_inj = 1'b0;
  endtask

  task automatic rd_req(input logic [2:0] p, input logic f);
    rd = 1'b1; rd_ptr = p; rd_free = f;
    tick();
    rd = 1'b0;
  endtask

  task automatic clr_err();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
  endtask

  task automatic check_beat(input string tag, input logic [63:0] d, input logic [7:0] m);
    check({tag, "_en"}, 64'(dfi_wrdata_en), 64'd1);
    check({tag, "_data"}, dfi_wrdata, d);
    check({tag, "_mask"}, 64'(dfi_wrdata_mask), 64'(m));
  endtask

  localparam logic [63:0] D1 = 64'h1111_1111_1111_1111;
  localparam logic [63:0] D2 = 64'h2222_2222_2222_2222;
  localparam logic [63:0] DA = 64'hAAAA_5555_0123_4567;
  localparam logic [63:0] DB = 64'h5555_AAAA_89AB_CDEF;
  localparam logic [63:0] DC = 64'hCAFE_F00D_DEAD_BEEF;
  localparam logic [63:0] DD = 64'h0F0F_F0F0_1234_5678;
  localparam logic [63:0] DE = 64'h0000_0000_0000_00FF;
  localparam logic [63:0] DF = 64'hFFFF_0000_FFFF_0000;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_en", 64'(dfi_wrdata_en), 64'd0);
    check("rst_data", dfi_wrdata, 64'd0);
    check("rst_busy", 64'(rd_busy), 64'd0);
    check("rst_valid", 64'(valid_vec), 64'd0);
    check("rst_err", 64'(err_code), 64'd0);
    check("rst_fir", 64'(fir), 64'd0);
    rstn = 1'b1;
    tick();

    // Basic burst to ptr 3, stream and free
    wbeat(3'd3, D1, 8'h00, 1'b0);
    check("t1_valid_partial", 64'(valid_vec), 64'h00);
    wbeat(3'd3, D2, 8'h0F, 1'b0);
    check("t1_valid", 64'(valid_vec), 64'h08);
    rd_req(3'd3, 1'b1);
    check("t1_lat_en", 64'(dfi_wrdata_en), 64'd0);
    tick();
    check_beat("t1_b0", D1, 8'h00);
    check("t1_busy", 64'(rd_busy), 64'd1);
    tick();
    check_beat("t1_b1", D2, 8'h0F);
    tick();
    check("t1_end_en", 64'(dfi_wrdata_en), 64'd0);
    check("t1_end_data", dfi_wrdata, 64'd0);
    check("t1_end_busy", 64'(rd_busy), 64'd0);
    check("t1_valid_after", 64'(valid_vec), 64'h00);
    check("t1_fir", 64'(fir), 64'd0);

    // Back-to-back replay of ptr 5 without freeing
    wbeat(3'd5, DA, 8'h01, 1'b0);
    wbeat(3'd5, DB, 8'h80, 1'b0);
    rd_req(3'd5, 1'b0);
    tick();
    check_beat("t2_b0", DA, 8'h01);
    rd = 1'b1; rd_ptr = 3'd5; rd_free = 1'b0;
    tick();
    rd = 1'b0;
    check_beat("t2_b1", DB, 8'h80);
    tick();
    check_beat("t2_b2", DA, 8'h01);
    tick();
    check_beat("t2_b3", DB, 8'h80);
    tick();
    check("t2_end_en", 64'(dfi_wrdata_en), 64'd0);
    check("t2_valid", 64'(valid_vec), 64'h20);
    check("t2_err", 64'(err_code), 64'd0);

    // Burst to an already valid entry is dropped
    wbeat(3'd5, 64'h7777_7777_7777_7777, 8'hFF, 1'b0);
    check("t3_err", 64'(err_code), 64'h1);
    check("t3_fir", 64'(fir), 64'd1);
    wbeat(3'd5, 64'h8888_8888_8888_8888, 8'hFF, 1'b0);
    rd_req(3'd5, 1'b1);
    tick();
    check_beat("t3_b0", DA, 8'h01);
    tick();
    check_beat("t3_b1", DB, 8'h80);
    clr_err();
    check("t3_clr_err", 64'(err_code), 64'd0);
    check("t3_clr_fir", 64'(fir), 64'd0);
    check("t3_valid", 64'(valid_vec), 64'h00);

    // Read of an empty entry
    rd_req(3'd2, 1'b0);
    check("t4_err", 64'(err_code), 64'h2);
    check("t4_en0", 64'(dfi_wrdata_en), 64'd0);
    tick();
    check("t4_en1", 64'(dfi_wrdata_en), 64'd0);
    clr_err();

    // rd during a stream is ignored
    wbeat(3'd6, DC, 8'h3C, 1'b0);
    wbeat(3'd6, DD, 8'hC3, 1'b0);
    rd = 1'b1; rd_ptr = 3'd6; rd_free = 1'b1;
    tick();
    tick();
    rd = 1'b0;
    check_beat("t4_b0", DC, 8'h3C);
    tick();
    check_beat("t4_b1", DD, 8'hC3);
    check("t4_busy_err", 64'(err_code), 64'h2);
    tick();
    check("t4_end_en", 64'(dfi_wrdata_en), 64'd0);
    check("t4_valid", 64'(valid_vec), 64'h00);
    clr_err();

    // Burst pointer change mid-burst
    wbeat(3'd1, D1, 8'h00, 1'b0);
    wbeat(3'd4, D2, 8'h00, 1'b0);
    check("t5_err", 64'(err_code), 64'h8);
    check("t5_valid", 64'(valid_vec), 64'h00);
    clr_err();

    // Parity injection on beat 0
    wbeat(3'd7, DE, 8'h00, 1'b1);
    wbeat(3'd7, DF, 8'h00, 1'b0);
    rd_req(3'd7, 1'b1);
    tick();
    check_beat("t5_b0", DE, 8'h00);
    check("t5_par_pre", 64'(err_code), 64'h0);
    tick();
    check_beat("t5_b1", DF, 8'h00);
    check("t5_par_err", 64'(err_code), 64'h4);
    tick();
    check("t5_par_hold", 64'(err_code), 64'h4);
    clr_err();
    check("t5_par_clr", 64'(err_code), 64'h0);

    // Asynchronous reset during a stream
    wbeat(3'd2, DC, 8'h11, 1'b0);
    wbeat(3'd2, DD, 8'h22, 1'b0);
    rd_req(3'd2, 1'b0);
    tick();
    check_beat("t6_b0", DC, 8'h11);
    #2;
    rstn = 1'b0;
    #1;
    check("t6_rst_en", 64'(dfi_wrdata_en), 64'd0);
    check("t6_rst_data", dfi_wrdata, 64'd0);
    check("t6_rst_busy", 64'(rd_busy), 64'd0);
    #2;
    rstn = 1'b1;
    tick();
    check("t6_valid", 64'(valid_vec), 64'h00);
    check("t6_err", 64'(err_code), 64'h0);
    check("t6_en_after", 64'(dfi_wrdata_en), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
